fetch_sequencer: RTL and testbench

- Program-counter controller for the 9-bit instruction ROM. It produces the D-bit fetch address, sequences start, run, stall and halt, and applies absolute jumps and PC-relative branches.
- Sits between the top-level start/done handshake, the decoder/ALU branch outputs and the ROM address input.
- Also counts retired instructions and elapsed run cycles for the bench and for performance reporting.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/sat_counter.sv | 33 +++
 rtl/fetch_sequencer.sv | 99 +++++++++
 tb/tb_fetch_sequencer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } seq_state_t;

  localparam int unsigned DDefault         = 9;
  localparam int unsigned StartAddrDefault = 0;
  localparam int unsigned OfsWDefault      = 8;
  localparam int unsigned CntWDefault      = 16;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/status bundle between the sequencer and its environment.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int unsigned D     = DDefault,
  parameter int unsigned OFS_W = OfsWDefault,
  parameter int unsigned CNT_W = CntWDefault
);
  logic             start;
  logic             stall;
  logic             halt_req;
  logic             jump_en;
  logic [D-1:0]     jump_target;
  logic             br_en;
  logic [OFS_W-1:0] br_ofs;
  logic [D-1:0]     prog_ctr;
  logic             fetch_valid;
  logic             done;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  // Environment side: drives control, observes PC and status.
  modport master (
    output start, stall, halt_req, jump_en, jump_target, br_en, br_ofs,
    input  prog_ctr, fetch_valid, done, instr_cnt, cycle_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, stall, halt_req, jump_en, jump_target, br_en, br_ofs,
    output prog_ctr, fetch_valid, done, instr_cnt, cycle_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  // Next count: clear, else increment unless already at all-ones.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller: start/run/stall/halt sequencing, jumps,
// PC-relative branches and retired-instruction / run-cycle counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned D          = DDefault,
  parameter int unsigned START_ADDR = StartAddrDefault,
  parameter int unsigned OFS_W      = OfsWDefault,
  parameter int unsigned CNT_W      = CntWDefault
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.slave bus
);
  localparam logic [D-1:0] StartPc = START_ADDR[D-1:0];

  seq_state_t   state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] ofs_ext;
  logic         cnt_clr;
  logic         instr_inc;
  logic         cycle_inc;

  // Offset is two's complement; PC arithmetic wraps modulo 2**D.
  assign ofs_ext = {{(D - OFS_W){bus.br_ofs[OFS_W-1]}}, bus.br_ofs};

  // Next state, next PC and counter strobes; halt > stall > jump > branch > increment.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_clr   = 1'b0;
    instr_inc = 1'b0;
    cycle_inc = 1'b0;
    case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          state_d = StRun;
          pc_d    = StartPc;
          cnt_clr = 1'b1;
        end
      end
      StRun: begin
        cycle_inc = 1'b1;
        if (bus.halt_req) begin
          // The halt instruction itself retires.
          state_d   = StHalt;
          instr_inc = 1'b1;
        end else if (!bus.stall) begin
          instr_inc = 1'b1;
          if (bus.jump_en) begin
            pc_d = bus.jump_target;
          end else if (bus.br_en) begin
            pc_d = pc_q + ofs_ext;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= StartPc;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (instr_inc),
    .q     (bus.instr_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cycle_inc),
    .q     (bus.cycle_cnt)
  );

  assign bus.prog_ctr    = pc_q;
  assign bus.fetch_valid = (state_q == StRun);
  assign bus.done        = (state_q == StHalt);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table plus hand-written corner sequences.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int unsigned NumVec = 18;

  typedef struct packed {
    logic        stall;
    logic        halt;
    logic        jmp;
    logic [8:0]  jt;
    logic        br;
    logic [7:0]  ofs;
    logic [8:0]  pc;
    logic [15:0] ic;
    logic [15:0] cc;
    logic        fv;
    logic        dn;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs [NumVec];

  always #5 clk = ~clk;

  fetch_sequencer_if #(.D(9), .OFS_W(8), .CNT_W(16)) bus ();

  fetch_sequencer #(
    .D          (9),
    .START_ADDR (0),
    .OFS_W      (8),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [8:0] pc, input logic [15:0] ic,
                           input logic [15:0] cc, input logic fv, input logic dn);
    check({name, ".prog_ctr"}, 32'(bus.prog_ctr), 32'(pc));
    check({name, ".instr_cnt"}, 32'(bus.instr_cnt), 32'(ic));
    check({name, ".cycle_cnt"}, 32'(bus.cycle_cnt), 32'(cc));
    check({name, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(fv));
    check({name, ".done"}, 32'(bus.done), 32'(dn));
  endtask

  function automatic vec_t mk(input logic stall, input logic halt, input logic jmp,
                              input logic [8:0] jt, input logic br, input logic [7:0] ofs,
                              input logic [8:0] pc, input logic [15:0] ic,
                              input logic [15:0] cc, input logic fv, input logic dn);
    vec_t v;
    v.stall = stall; v.halt = halt; v.jmp = jmp; v.jt = jt; v.br = br; v.ofs = ofs;
    v.pc = pc; v.ic = ic; v.cc = cc; v.fv = fv; v.dn = dn;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.stall = 1'b0; bus.halt_req = 1'b0; bus.jump_en = 1'b0;
    bus.jump_target = '0; bus.br_en = 1'b0; bus.br_ofs = '0;
  endtask

  initial begin
    //            stall halt jmp  jt      br   ofs      pc      ic  cc  fv dn
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd1,   1,  1,  1, 0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd2,   2,  2,  1, 0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd3,   3,  3,  1, 0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd3,   3,  4,  1, 0);
    vecs[4]  = mk(1'b1, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd3,   3,  5,  1, 0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd4,   4,  6,  1, 0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd5,   5,  7,  1, 0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 9'd10,  1'b0, 8'h00, 9'd10,  6,  8,  1, 0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 8'hFC, 9'd6,   7,  9,  1, 0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 9'd1,   1'b0, 8'h00, 9'd1,   8,  10, 1, 0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b1, 8'hFD, 9'd510, 9,  11, 1, 0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd511, 10, 12, 1, 0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 9'd0,   1'b0, 8'h00, 9'd0,   11, 13, 1, 0);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 9'd100, 1'b1, 8'h05, 9'd100, 12, 14, 1, 0);
    vecs[14] = mk(1'b1, 1'b0, 1'b1, 9'd200, 1'b0, 8'h00, 9'd100, 12, 15, 1, 0);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 9'd7,   1'b0, 8'h00, 9'd7,   13, 16, 1, 0);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 9'd0,   1'b0, 8'h00, 9'd7,   14, 17, 0, 1);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 9'd50,  1'b0, 8'h00, 9'd7,   14, 17, 0, 1);

    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check_all("reset", 9'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("idle", 9'd0, 16'd0, 16'd0, 1'b0, 1'b0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("start", 9'd0, 16'd0, 16'd0, 1'b1, 1'b0);

    for (int i = 0; i < int'(NumVec); i++) begin
      bus.stall       = vecs[i].stall;
      bus.halt_req    = vecs[i].halt;
      bus.jump_en     = vecs[i].jmp;
      bus.jump_target = vecs[i].jt;
      bus.br_en       = vecs[i].br;
      bus.br_ofs      = vecs[i].ofs;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ic, vecs[i].cc, vecs[i].fv,
                vecs[i].dn);
    end
    idle_inputs();

    // Restart from HALT clears counters and reloads the start address.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("restart", 9'd0, 16'd0, 16'd0, 1'b1, 1'b0);

    // start while running is ignored.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_all("start_in_run", 9'd1, 16'd1, 16'd1, 1'b1, 1'b0);

    bus.jump_en = 1'b1;
    bus.jump_target = 9'd42;
    tick();
    check_all("jump42", 9'd42, 16'd2, 16'd2, 1'b1, 1'b0);

    // Reset beats a pending jump.
    bus.jump_target = 9'd300;
    rst_n = 1'b0;
    tick();
    check_all("reset_mid_run", 9'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("idle_ignores_jump", 9'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    idle_inputs();

    // Cycle counter saturation under a long stall.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stall = 1'b1;
    repeat (65539) tick();
    check_all("sat_stall", 9'd0, 16'd0, 16'hFFFF, 1'b1, 1'b0);
    bus.halt_req = 1'b1;
    tick();
    check_all("sat_halt", 9'd0, 16'd1, 16'hFFFF, 1'b0, 1'b1);
    idle_inputs();
    tick();
    check_all("halt_frozen", 9'd0, 16'd1, 16'hFFFF, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
